// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode receiver.
// Synchronises and deglitches the keyboard clock, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop), folds the E0/F0 prefixes into
// flags and presents each completed key in a one-entry output slot.
//
// Slot handshake: key_valid high means key_code/key_extended/key_release hold
// a key that has not been consumed; a cycle with key_valid=1 and key_ack=1
// transfers it. The slot fields never change while key_valid=1 unless that
// same cycle is a transfer. A key that completes while the slot is occupied
// and not being acked is dropped and sets the sticky overrun flag.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       frame_error,
    output logic       overrun,
    output logic [1:0] frame_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FCW-1:0]        filt_cnt;
    logic                  filt_clk;
    logic                  filt_clk_d;
    logic [FILTER_LEN-1:0] data_pipe;
    logic                  sample_evt;
    logic                  sample_bit;

    state_t                state;
    state_t                state_next;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift_reg;
    logic                  parity_bit;
    logic                  parity_ok;
    logic [WDW-1:0]        wd_cnt;
    logic                  timeout;
    logic                  byte_done_c;
    logic                  frame_err_c;

    logic                  byte_stb;
    logic [7:0]            byte_q;
    logic                  ext_flag;
    logic                  rel_flag;
    logic                  key_done;
    logic                  ack_taken;

    // Two-flop synchronisers; lines idle high so the flops reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Clock deglitch: follow the synchronised level only after it has
    // disagreed with the filtered level for FILTER_LEN cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Data delay line so the sampled bit matches the filtered clock latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_pipe <= '1;
        end else begin
            data_pipe <= {data_pipe[FILTER_LEN-2:0], data_sync[1]};
        end
    end

    assign sample_evt = filt_clk_d & ~filt_clk;
    assign sample_bit = data_pipe[FILTER_LEN-1];
    assign parity_ok  = ^{shift_reg, parity_bit};
    assign timeout    = (state != IDLE) && !sample_evt &&
                        (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

    // Frame FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame FSM next state: advances only on sample events, watchdog wins.
    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (sample_evt) begin
            case (state)
                IDLE:    if (!sample_bit) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Frame FSM outputs: byte accepted or frame discarded.
    always_comb begin
        byte_done_c = 1'b0;
        frame_err_c = 1'b0;
        if (timeout) begin
            frame_err_c = 1'b1;
        end else if (sample_evt && state == STOP) begin
            if (sample_bit && parity_ok) begin
                byte_done_c = 1'b1;
            end else begin
                frame_err_c = 1'b1;
            end
        end
    end

    // Frame datapath: bit counter, data shifter and parity capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
        end else if (state == IDLE) begin
            bit_cnt <= 3'd0;
        end else if (sample_evt) begin
            if (state == DATA) begin
                shift_reg <= {sample_bit, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end else if (state == PARITY) begin
                parity_bit <= sample_bit;
            end
        end
    end

    // Watchdog: counts idle time inside a frame, restarts on every bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == IDLE || sample_evt || timeout) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Registered byte strobe and error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_stb    <= 1'b0;
            byte_q      <= 8'h00;
            frame_error <= 1'b0;
        end else begin
            byte_stb    <= byte_done_c;
            frame_error <= frame_err_c;
            if (byte_done_c) byte_q <= shift_reg;
        end
    end

    assign key_done  = byte_stb && byte_q != 8'hE0 && byte_q != 8'hF0;
    assign ack_taken = key_valid && key_ack;

    // Prefix flags: set by E0/F0, cleared by a finished key or a bad frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
        end else if (frame_error || key_done) begin
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
        end else if (byte_stb) begin
            if (byte_q == 8'hE0) ext_flag <= 1'b1;
            if (byte_q == 8'hF0) rel_flag <= 1'b1;
        end
    end

    // Output slot with drop-on-full and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_release  <= 1'b0;
            key_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (ack_taken) overrun <= 1'b0;
            if (key_done && (!key_valid || key_ack)) begin
                key_code     <= byte_q;
                key_extended <= ext_flag;
                key_release  <= rel_flag;
                key_valid    <= 1'b1;
            end else if (key_done) begin
                overrun <= 1'b1;
            end else if (ack_taken) begin
                key_valid <= 1'b0;
            end
        end
    end

    assign frame_state = state;

endmodule
